fft_frame_collector: RTL and testbench
======================================

Name: fft_frame_collector

Overview:
- Sits directly upstream of the spectrum-analysis stage (peak-bin finder).
- Accepts FFT results one bin per cycle from the serial FFT core and reorders bins from bit-reversed to natural order when configured.
- Presents a complete 16-bin frame in parallel on fft_d0..fft_d15, with a one-cycle fft_valid pulse, to drive the analysis stage directly.
- Output registers act as a shadow buffer, so the next frame can be collected while the current frame is held.

Parameters:
- BIT_REV, 1: 1 = input bins arrive in bit-reversed order (slot = bitrev4(k)); 0 = natural order (slot = k).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data/in_sof valid this cycle; sample accepted on the rising edge.
- in_sof  input  1  start of frame; meaningful only when in_valid=1.
- in_data  input  32  one FFT bin: [31:16] real, [15:0] imaginary, both signed 16-bit.
- fft_valid  output  1  one-cycle pulse: fft_d0..fft_d15 hold a new complete frame.
- fft_d0..fft_d15  output  32 each  frame bins in natural order, same packing as in_data; held between frames.
- frame_err  output  1  one-cycle pulse: a partial frame was discarded by an early in_sof.

Behaviour:
- Reset (async, rst=1): sample counter cnt=0; fft_valid=0; frame_err=0; fft_d0..fft_d15=0; capture array cleared to 0. No frame is emitted for any samples accepted before reset.
- Sample index k:
  - k = 0 when in_valid=1 and in_sof=1.
  - Otherwise k = cnt.
  - Storage slot = BIT_REV ? {k[0],k[1],k[2],k[3]} : k.
- Accept (in_valid=1):
  - capture[slot] <= in_data.
  - cnt <= k+1 mod 16; cnt wraps from 15 to 0.
- Gaps (in_valid=0): cnt and capture array hold; in_sof is ignored. Arbitrary gaps within a frame are legal.
- Frame completion (accept with k=15):
  - On that same edge, all 16 output registers load together: slots not written on this edge take capture[], and the slot written on this edge takes in_data directly.
  - fft_valid=1 for exactly the next cycle; latency is 1 cycle from the 16th sample edge to visible outputs.
- Outputs hold until the next completion; fft_valid=0 at all other times.
- Early sof (in_valid=1, in_sof=1, cnt!=0):
  - The partial frame is discarded and frame_err=1 for one cycle.
  - The sample is written as k=0 and cnt becomes 1.
  - Stale capture entries are harmless because a full frame rewrites all 16 slots.
- in_sof with cnt=0: normal frame start, no error.
- Throughput: back-to-back frames at one sample per cycle are sustained; fft_valid is asserted at most once per 16 cycles. No backpressure; the downstream stage must sample on the fft_valid cycle.
- Data passes through bit-exact; no arithmetic, saturation or sign handling.

Decomposition:
- Shared package:
  - FFT_N=16, FFT_IDX_W=4, FFT_DW=32, FFT_RE_MSB=31, FFT_IM_MSB=15.
  - Function bitrev4(idx); the FFT core and this block use the same function.
- No sub-module. The single module holds the counter, capture array and output shadow registers.

Test Plan:
- BIT_REV=0, 16 consecutive samples with in_data=k*0x00010001, sof on k=0 -> fft_valid high exactly one cycle after the 16th edge; fft_dk = k*0x00010001 (e.g. fft_d15=0x000F000F).
- BIT_REV=1, in_data=k for k=0..15 -> fft_d8=1, fft_d4=2, fft_d12=3, fft_d15=15, fft_d0=0; single fft_valid pulse.
- BIT_REV=0, in_valid toggled 1/0 every cycle for 16 samples -> identical outputs; one fft_valid on the cycle after the 16th accept; no pulse during gaps.
- 5 samples, then in_sof with in_valid=1, then 15 more samples -> frame_err pulses one cycle on the sof edge; fft_valid only after the 15th post-sof sample; outputs hold the post-sof frame only.
- 32 consecutive samples (two frames, frame 2 data = k+0x100) -> fft_valid pulses at cycles 16 and 32, each 1 cycle wide; between pulses the outputs hold frame 1; after cycle 32, fft_d3=0x103 (BIT_REV=0).
- rst asserted asynchronously mid-cycle after 8 samples -> all outputs 0 immediately; then 16 samples -> exactly one fft_valid and a correct frame; no residue from the 8 pre-reset samples.

Source files
------------

// File: rtl/fft_frame_collector_pkg.sv
// ---------------------------------------------------------------------------
// fft_frame_collector_pkg
// Shared constants and types for the serial FFT core and the frame collector.
// The bitrev4() function is shared with the FFT core so that both agree
// on the bin ordering.
// ---------------------------------------------------------------------------
package fft_frame_collector_pkg;

    localparam int unsigned FFT_N      = 16;  // bins per frame
    localparam int unsigned FFT_IDX_W  = 4;   // bits needed to index a bin
    localparam int unsigned FFT_DW     = 32;  // packed complex bin width
    localparam int unsigned FFT_RE_MSB = 31;  // real part occupies [31:16]
    localparam int unsigned FFT_IM_MSB = 15;  // imaginary part occupies [15:0]

    typedef logic [FFT_DW-1:0]    fft_bin_t;
    typedef logic [FFT_IDX_W-1:0] fft_idx_t;

    // Reverse the 4 index bits: converts a bit-reversed bin index to natural.
    function automatic fft_idx_t bitrev4(input fft_idx_t idx);
        return {idx[0], idx[1], idx[2], idx[3]};
    endfunction

endpackage

// File: rtl/fft_frame_collector.sv
// ---------------------------------------------------------------------------
// fft_frame_collector
// Collects 16 FFT bins arriving one per cycle, optionally undoes the
// bit-reversed ordering, and presents the whole frame in parallel with a
// one-cycle fft_valid pulse. The output registers form a shadow buffer, so
// the next frame is collected while the current one is held.
//
// Ports:
//   clk            system clock, rising-edge
//   rst            asynchronous active-high reset
//   in_valid       in_data / in_sof valid this cycle
//   in_sof         start of frame (only when in_valid=1)
//   in_data        one bin: [31:16] real, [15:0] imaginary
//   fft_valid      one-cycle pulse: fft_d0..fft_d15 hold a new frame
//   fft_d0..d15    frame bins in natural order, held between frames
//   frame_err      one-cycle pulse: partial frame dropped by early in_sof
// ---------------------------------------------------------------------------
module fft_frame_collector
    import fft_frame_collector_pkg::*;
#(
    parameter bit BIT_REV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [FFT_DW-1:0] in_data,
    output logic              fft_valid,
    output logic [FFT_DW-1:0] fft_d0,
    output logic [FFT_DW-1:0] fft_d1,
    output logic [FFT_DW-1:0] fft_d2,
    output logic [FFT_DW-1:0] fft_d3,
    output logic [FFT_DW-1:0] fft_d4,
    output logic [FFT_DW-1:0] fft_d5,
    output logic [FFT_DW-1:0] fft_d6,
    output logic [FFT_DW-1:0] fft_d7,
    output logic [FFT_DW-1:0] fft_d8,
    output logic [FFT_DW-1:0] fft_d9,
    output logic [FFT_DW-1:0] fft_d10,
    output logic [FFT_DW-1:0] fft_d11,
    output logic [FFT_DW-1:0] fft_d12,
    output logic [FFT_DW-1:0] fft_d13,
    output logic [FFT_DW-1:0] fft_d14,
    output logic [FFT_DW-1:0] fft_d15,
    output logic              frame_err
);

    fft_idx_t r_cnt;
    fft_bin_t r_capture [FFT_N];
    fft_bin_t r_out     [FFT_N];
    logic     r_valid;
    logic     r_err;

    fft_idx_t w_k;
    fft_idx_t w_slot;
    logic     w_done;
    logic     w_early;

    // An accepted in_sof restarts the frame at index 0 regardless of cnt.
    assign w_k     = (in_valid && in_sof) ? '0 : r_cnt;
    assign w_slot  = BIT_REV ? bitrev4(w_k) : w_k;
    assign w_done  = in_valid && (w_k == fft_idx_t'(FFT_N - 1));
    assign w_early = in_valid && in_sof && (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            // NOTE: the capture array is reset on purpose so no data from
            // before reset can ever reach the outputs; a plain storage RAM
            // would normally be left unreset.
            for (int i = 0; i < FFT_N; i++) begin
                r_capture[i] <= '0;
                r_out[i]     <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge register values and the order of
            // statements does not matter.
            r_valid <= w_done;
            r_err   <= w_early;
            if (in_valid) begin
                r_capture[w_slot] <= in_data;
                r_cnt             <= w_k + fft_idx_t'(1);
            end
            // The last bin is still in flight into r_capture on this edge,
            // so its output slot is loaded straight from in_data.
            if (w_done) begin
                for (int i = 0; i < FFT_N; i++) begin
                    r_out[i] <= (w_slot == fft_idx_t'(i)) ? in_data : r_capture[i];
                end
            end
        end
    end

    assign fft_valid = r_valid;
    assign frame_err = r_err;
    assign fft_d0    = r_out[0];
    assign fft_d1    = r_out[1];
    assign fft_d2    = r_out[2];
    assign fft_d3    = r_out[3];
    assign fft_d4    = r_out[4];
    assign fft_d5    = r_out[5];
    assign fft_d6    = r_out[6];
    assign fft_d7    = r_out[7];
    assign fft_d8    = r_out[8];
    assign fft_d9    = r_out[9];
    assign fft_d10   = r_out[10];
    assign fft_d11   = r_out[11];
    assign fft_d12   = r_out[12];
    assign fft_d13   = r_out[13];
    assign fft_d14   = r_out[14];
    assign fft_d15   = r_out[15];

endmodule

// File: tb/tb_fft_frame_collector.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_collector
// Drives one natural-order (BIT_REV=0) and one bit-reversed (BIT_REV=1)
// instance with the same stimulus and checks both against hand-computed
// frames.
// ---------------------------------------------------------------------------
module tb_fft_frame_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [31:0] in_data;

    logic        fft_valid_a, fft_valid_b;
    logic        frame_err_a, frame_err_b;
    logic [31:0] da [16];
    logic [31:0] db [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_frame_collector #(.BIT_REV(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .fft_valid(fft_valid_a),
        .fft_d0(da[0]),   .fft_d1(da[1]),   .fft_d2(da[2]),   .fft_d3(da[3]),
        .fft_d4(da[4]),   .fft_d5(da[5]),   .fft_d6(da[6]),   .fft_d7(da[7]),
        .fft_d8(da[8]),   .fft_d9(da[9]),   .fft_d10(da[10]), .fft_d11(da[11]),
        .fft_d12(da[12]), .fft_d13(da[13]), .fft_d14(da[14]), .fft_d15(da[15]),
        .frame_err(frame_err_a)
    );

    fft_frame_collector #(.BIT_REV(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .fft_valid(fft_valid_b),
        .fft_d0(db[0]),   .fft_d1(db[1]),   .fft_d2(db[2]),   .fft_d3(db[3]),
        .fft_d4(db[4]),   .fft_d5(db[5]),   .fft_d6(db[6]),   .fft_d7(db[7]),
        .fft_d8(db[8]),   .fft_d9(db[9]),   .fft_d10(db[10]), .fft_d11(db[11]),
        .fft_d12(db[12]), .fft_d13(db[13]), .fft_d14(db[14]), .fft_d15(db[15]),
        .frame_err(frame_err_b)
    );

    // Independent 4-bit reversal used to build the expected BIT_REV=1 frames.
    function automatic logic [3:0] rev4(input int x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[3-i] = 1'((x >> i) & 1);
        return r;
    endfunction

    // Apply one cycle of input, then sample 1 time unit after the edge.
    task automatic send(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        #12;
        total++;
        if (fft_valid_a !== 1'b0 || fft_valid_b !== 1'b0) begin
            bad++; $display("FAIL reset fft_valid got a=%b b=%b exp 0", fft_valid_a, fft_valid_b);
        end
        total++;
        if (frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
            bad++; $display("FAIL reset frame_err got a=%b b=%b exp 0", frame_err_a, frame_err_b);
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'h0 || db[j] !== 32'h0) begin
                bad++; $display("FAIL reset d[%0d] got a=%h b=%h exp 0", j, da[j], db[j]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_natural;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 1'(k == 0), 32'(k) * 32'h0001_0001);
            total++;
            if (fft_valid_a !== 1'(k == 15) || fft_valid_b !== 1'(k == 15)) begin
                bad++; $display("FAIL natural valid k=%0d got a=%b b=%b exp %b", k, fft_valid_a, fft_valid_b, k == 15);
            end
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'(j) * 32'h0001_0001) begin
                bad++; $display("FAIL natural a d[%0d] got %h exp %h", j, da[j], 32'(j) * 32'h0001_0001);
            end
            total++;
            if (db[j] !== 32'(rev4(j)) * 32'h0001_0001) begin
                bad++; $display("FAIL natural b d[%0d] got %h exp %h", j, db[j], 32'(rev4(j)) * 32'h0001_0001);
            end
        end
        total++;
        if (da[15] !== 32'h000F_000F) begin
            bad++; $display("FAIL natural a d15 got %h exp 000f000f", da[15]);
        end
        send(1'b0, 1'b0, 32'h0);
        total++;
        if (fft_valid_a !== 1'b0 || fft_valid_b !== 1'b0) begin
            bad++; $display("FAIL natural pulse width got a=%b b=%b exp 0", fft_valid_a, fft_valid_b);
        end
    endtask

    task automatic test_bitrev;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 1'(k == 0), 32'(k));
            total++;
            if (fft_valid_b !== 1'(k == 15)) begin
                bad++; $display("FAIL bitrev valid k=%0d got %b exp %b", k, fft_valid_b, k == 15);
            end
        end
        total++;
        if (db[8] !== 32'd1 || db[4] !== 32'd2 || db[12] !== 32'd3 || db[15] !== 32'd15 || db[0] !== 32'd0) begin
            bad++; $display("FAIL bitrev spot got d8=%h d4=%h d12=%h d15=%h d0=%h exp 1 2 3 f 0",
                            db[8], db[4], db[12], db[15], db[0]);
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (db[j] !== 32'(rev4(j)) || da[j] !== 32'(j)) begin
                bad++; $display("FAIL bitrev d[%0d] got b=%h a=%h exp b=%h a=%h", j, db[j], da[j], 32'(rev4(j)), 32'(j));
            end
        end
        send(1'b0, 1'b0, 32'h0);
        total++;
        if (fft_valid_b !== 1'b0 || db[8] !== 32'd1) begin
            bad++; $display("FAIL bitrev hold got valid=%b d8=%h exp 0 1", fft_valid_b, db[8]);
        end
    endtask

    task automatic test_gaps;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 1'(k == 0), 32'(k) * 32'h0001_0001);
            total++;
            if (fft_valid_a !== 1'(k == 15) || fft_valid_b !== 1'(k == 15)) begin
                bad++; $display("FAIL gaps valid k=%0d got a=%b b=%b exp %b", k, fft_valid_a, fft_valid_b, k == 15);
            end
            if (k < 15) begin
                // in_sof and junk data during a gap must be ignored.
                send(1'b0, 1'b1, 32'hDEAD_BEEF);
                total++;
                if (fft_valid_a !== 1'b0 || frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
                    bad++; $display("FAIL gaps idle k=%0d got valid=%b err a=%b b=%b exp 0", k, fft_valid_a, frame_err_a, frame_err_b);
                end
            end
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'(j) * 32'h0001_0001 || db[j] !== 32'(rev4(j)) * 32'h0001_0001) begin
                bad++; $display("FAIL gaps d[%0d] got a=%h b=%h exp a=%h b=%h", j, da[j], db[j],
                                32'(j) * 32'h0001_0001, 32'(rev4(j)) * 32'h0001_0001);
            end
        end
        send(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_early_sof;
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 1'(k == 0), 32'h500 + 32'(k));
            total++;
            if (frame_err_a !== 1'b0 || fft_valid_a !== 1'b0) begin
                bad++; $display("FAIL early pre k=%0d got err=%b valid=%b exp 0 0", k, frame_err_a, fft_valid_a);
            end
        end
        send(1'b1, 1'b1, 32'h1000);
        total++;
        if (frame_err_a !== 1'b1 || frame_err_b !== 1'b1) begin
            bad++; $display("FAIL early err pulse got a=%b b=%b exp 1", frame_err_a, frame_err_b);
        end
        for (int k = 1; k < 16; k++) begin
            send(1'b1, 1'b0, 32'h1000 + 32'(k));
            total++;
            if (frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
                bad++; $display("FAIL early err k=%0d got a=%b b=%b exp 0", k, frame_err_a, frame_err_b);
            end
            total++;
            if (fft_valid_a !== 1'(k == 15) || fft_valid_b !== 1'(k == 15)) begin
                bad++; $display("FAIL early valid k=%0d got a=%b b=%b exp %b", k, fft_valid_a, fft_valid_b, k == 15);
            end
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'h1000 + 32'(j) || db[j] !== 32'h1000 + 32'(rev4(j))) begin
                bad++; $display("FAIL early d[%0d] got a=%h b=%h exp a=%h b=%h", j, da[j], db[j],
                                32'h1000 + 32'(j), 32'h1000 + 32'(rev4(j)));
            end
        end
        send(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 32; k++) begin
            send(1'b1, 1'(k == 0), (k < 16) ? 32'(k) : 32'h100 + 32'(k - 16));
            total++;
            if (fft_valid_a !== 1'(k == 15 || k == 31) || fft_valid_b !== 1'(k == 15 || k == 31)) begin
                bad++; $display("FAIL b2b valid k=%0d got a=%b b=%b exp %b", k, fft_valid_a, fft_valid_b, k == 15 || k == 31);
            end
            if (k == 20 || k == 30) begin
                for (int j = 0; j < 16; j++) begin
                    total++;
                    if (da[j] !== 32'(j) || db[j] !== 32'(rev4(j))) begin
                        bad++; $display("FAIL b2b hold k=%0d d[%0d] got a=%h b=%h exp a=%h b=%h", k, j, da[j], db[j],
                                        32'(j), 32'(rev4(j)));
                    end
                end
            end
        end
        total++;
        if (da[3] !== 32'h103) begin
            bad++; $display("FAIL b2b a d3 got %h exp 103", da[3]);
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'h100 + 32'(j) || db[j] !== 32'h100 + 32'(rev4(j))) begin
                bad++; $display("FAIL b2b frame2 d[%0d] got a=%h b=%h exp a=%h b=%h", j, da[j], db[j],
                                32'h100 + 32'(j), 32'h100 + 32'(rev4(j)));
            end
        end
        send(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 8; k++) send(1'b1, 1'(k == 0), 32'h7700 + 32'(k));
        // Assert reset between clock edges: outputs must clear without a clock.
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (fft_valid_a !== 1'b0 || fft_valid_b !== 1'b0 || frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
            bad++; $display("FAIL rstmid flags got va=%b vb=%b ea=%b eb=%b exp 0", fft_valid_a, fft_valid_b, frame_err_a, frame_err_b);
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'h0 || db[j] !== 32'h0) begin
                bad++; $display("FAIL rstmid d[%0d] got a=%h b=%h exp 0", j, da[j], db[j]);
            end
        end
        #2;
        rst = 1'b0;
        // No sof: the counter must restart at 0 purely because of reset.
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 1'b0, 32'h3300 + 32'(k));
            total++;
            if (fft_valid_a !== 1'(k == 15) || fft_valid_b !== 1'(k == 15)) begin
                bad++; $display("FAIL rstmid valid k=%0d got a=%b b=%b exp %b", k, fft_valid_a, fft_valid_b, k == 15);
            end
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (da[j] !== 32'h3300 + 32'(j) || db[j] !== 32'h3300 + 32'(rev4(j))) begin
                bad++; $display("FAIL rstmid d[%0d] got a=%h b=%h exp a=%h b=%h", j, da[j], db[j],
                                32'h3300 + 32'(j), 32'h3300 + 32'(rev4(j)));
            end
        end
        send(1'b0, 1'b0, 32'h0);
        total++;
        if (fft_valid_a !== 1'b0 || fft_valid_b !== 1'b0) begin
            bad++; $display("FAIL rstmid extra pulse got a=%b b=%b exp 0", fft_valid_a, fft_valid_b);
        end
    endtask

    initial begin
        test_reset;
        test_natural;
        test_bitrev;
        test_gaps;
        test_early_sof;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
